// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared APB widths, arbiter FSM states and grant helpers
package apb_pkg;

    localparam int APB_ADDR_W = 8;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_arb_state_e;

    // Grant is a requester index; handshake outputs are one-hot per requester.
    function automatic logic [1:0] grant_onehot(input logic g);
        return g ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/apb_master_arbiter_if.sv
// rtl/apb_master_arbiter_if.sv - APB bus signal set with master/slave modports
interface apb_master_arbiter_if
    import apb_pkg::*;
#(
    parameter int ADDR_W = APB_ADDR_W,
    parameter int DATA_W = APB_DATA_W
);

    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/apb_master_arbiter_rr_arbiter.sv
// rtl/apb_master_arbiter_rr_arbiter.sv - two-way round-robin grant selection
module apb_rr_arbiter (
    input  logic [1:0] req_valid,
    input  logic       last_grant,
    output logic       grant,
    output logic       grant_any
);

    always_comb begin
        grant     = 1'b0;
        grant_any = |req_valid;
        // On a tie the requester that did not win last time goes next.
        if (&req_valid) begin
            grant = ~last_grant;
        end else if (req_valid[1]) begin
            grant = 1'b1;
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// rtl/apb_master_arbiter.sv - two-requester APB master; optional APB_ARB_TIMEOUT_EN access timeout
module apb_master_arbiter
    import apb_pkg::*;
#(
    parameter int ADDR_W         = APB_ADDR_W,
    parameter int DATA_W         = APB_DATA_W,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                pclk,
    input  logic                prst,
    input  logic [1:0]          req_valid,
    input  logic [1:0]          req_write,
    input  logic [2*ADDR_W-1:0] req_addr,
    input  logic [2*DATA_W-1:0] req_wdata,
    output logic [1:0]          req_ready,
    output logic [1:0]          rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    apb_master_arbiter_if.master apb
);

    apb_arb_state_e state_q;
    apb_arb_state_e state_d;

    logic last_grant;
    logic grant;
    logic grant_any;
    logic load;
    logic done;
    logic timeout_hit;

    apb_rr_arbiter u_rr (
        .req_valid  (req_valid),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_any  (grant_any)
    );

`ifdef APB_ARB_TIMEOUT_EN
    localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TCNT_W-1:0] tout_cnt;

    // Held at zero outside ACCESS, so it is clear on every ACCESS entry.
    always_ff @(posedge pclk) begin
        if (prst || (state_q != ACCESS)) begin
            tout_cnt <= '0;
        end else if (!apb.pready) begin
            tout_cnt <= tout_cnt + 1'b1;
        end
    end

    assign timeout_hit = (state_q == ACCESS) && !apb.pready &&
                         (tout_cnt == TCNT_W'(TIMEOUT_CYCLES - 1));
`else
    // No timeout in this build; the parameter only keeps the port list common.
    assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge pclk) begin
        if (prst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (grant_any) begin
                    state_d = SETUP;
                    load    = 1'b1;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (apb.pready || timeout_hit) begin
                    state_d = IDLE;
                    done    = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign apb.psel    = (state_q != IDLE);
    assign apb.penable = (state_q == ACCESS);
    assign req_ready   = (state_q == SETUP) ? grant_onehot(last_grant) : 2'b00;

    // Address/data are captured once at grant and held through IDLE.
    always_ff @(posedge pclk) begin
        if (prst) begin
            last_grant <= 1'b1;
            apb.paddr  <= '0;
            apb.pwdata <= '0;
            apb.pwrite <= 1'b0;
        end else if (load) begin
            last_grant <= grant;
            apb.paddr  <= grant ? req_addr[ADDR_W +: ADDR_W]  : req_addr[0 +: ADDR_W];
            apb.pwdata <= grant ? req_wdata[DATA_W +: DATA_W] : req_wdata[0 +: DATA_W];
            apb.pwrite <= grant ? req_write[1] : req_write[0];
        end
    end

    // A completion without pready can only be a timeout, which reports an error.
    always_ff @(posedge pclk) begin
        if (prst) begin
            rsp_valid <= 2'b00;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 2'b00;
            if (done) begin
                rsp_valid <= grant_onehot(last_grant);
                rsp_err   <= apb.pready ? apb.pslverr : 1'b1;
                rsp_rdata <= (apb.pready && !apb.pwrite) ? apb.prdata : '0;
            end
        end
    end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb/tb_apb_master_arbiter.sv - scoreboard bench for apb_master_arbiter
module tb_apb_master_arbiter;
    import apb_pkg::*;

    localparam int ADDR_W         = 8;
    localparam int DATA_W         = 32;
    localparam int TIMEOUT_CYCLES = 16;

    logic                pclk = 1'b0;
    logic                prst = 1'b1;
    logic [1:0]          req_valid = '0;
    logic [1:0]          req_write = '0;
    logic [2*ADDR_W-1:0] req_addr  = '0;
    logic [2*DATA_W-1:0] req_wdata = '0;
    logic [1:0]          req_ready;
    logic [1:0]          rsp_valid;
    logic [DATA_W-1:0]   rsp_rdata;
    logic                rsp_err;

    apb_master_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) apb ();

    apb_master_arbiter #(
        .ADDR_W         (ADDR_W),
        .DATA_W         (DATA_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .pclk      (pclk),
        .prst      (prst),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .apb       (apb)
    );

    always #5 pclk = ~pclk;

    // Slave model: pready stays low for wait_n ACCESS cycles, then rises.
    int          wait_n = 0;
    int          acc_n  = 0;
    logic [31:0] rd_val = '0;
    logic        err_val = 1'b0;

    always @(posedge pclk) begin
        if (apb.psel && apb.penable && !apb.pready) acc_n <= acc_n + 1;
        else acc_n <= 0;
    end

    assign apb.pready  = (acc_n >= wait_n);
    assign apb.prdata  = rd_val;
    assign apb.pslverr = err_val;

    typedef struct packed {
        logic [1:0]  mask;
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic expect_rsp(input logic [1:0] m, input logic [31:0] rd, input logic er);
        rsp_t e;
        e.mask  = m;
        e.rdata = rd;
        e.err   = er;
        sb.push_back(e);
    endtask

    always @(negedge pclk) begin
        rsp_t e;
        if (!prst) begin
            if ((req_ready & rsp_valid) != 2'b00)
                check("pulse_overlap", 64'(req_ready & rsp_valid), 64'd0);
            if (rsp_valid != 2'b00) begin
                if (sb.size() == 0) begin
                    check("rsp_unexpected", 64'(rsp_valid), 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("rsp_mask",  64'(rsp_valid), 64'(e.mask));
                    check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                    check("rsp_err",   64'(rsp_err),   64'(e.err));
                end
            end
        end
    end

    task automatic wait_ready(output int n);
        n = 0;
        do begin
            @(negedge pclk);
            n++;
        end while (req_ready == 2'b00 && n < 20);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge pclk);
            n++;
        end
        check("sb_drain", 64'(sb.size()), 64'd0);
    endtask

    task automatic set_req(input int id, input logic wr, input logic [7:0] addr, input logic [31:0] wd);
        req_write[id]               = wr;
        req_addr[id*ADDR_W +: ADDR_W] = addr;
        req_wdata[id*DATA_W +: DATA_W] = wd;
    endtask

    task automatic xfer(input int id, input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                        input int waits, input logic [31:0] rd, input logic er);
        int         n;
        logic [1:0] m;
        m       = (id != 0) ? 2'b10 : 2'b01;
        wait_n  = waits;
        rd_val  = rd;
        err_val = er;
        expect_rsp(m, wr ? 32'd0 : rd, er);
        set_req(id, wr, addr, wd);
        req_valid[id] = 1'b1;
        wait_ready(n);
        check("ready_latency", 64'(n), 64'd1);
        check("ready_mask",    64'(req_ready), 64'(m));
        check("setup_ctl",     64'({apb.psel, apb.penable}), 64'(2'b10));
        check("setup_addr",    64'(apb.paddr), 64'(addr));
        check("setup_write",   64'(apb.pwrite), 64'(wr));
        if (wr) check("setup_wdata", 64'(apb.pwdata), 64'(wd));
        req_valid[id] = 1'b0;
        n = 0;
        do begin
            @(negedge pclk);
            if (rsp_valid == 2'b00) begin
                n++;
                check("access_ctl",  64'({apb.psel, apb.penable, apb.pwrite}), 64'({2'b11, wr}));
                check("access_addr", 64'(apb.paddr), 64'(addr));
            end
        end while (rsp_valid == 2'b00 && n < 200);
        check("access_cycles", 64'(n), 64'(waits + 1));
        check("idle_psel",     64'({apb.psel, apb.penable}), 64'd0);
    endtask

    task automatic check_outs_zero(input string tag);
        check({tag, "_ctl"}, 64'({apb.psel, apb.penable, apb.pwrite, req_ready, rsp_valid, rsp_err, apb.paddr}), 64'd0);
        check({tag, "_data"}, {apb.pwdata, rsp_rdata}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int n;
        int held;

        // Reset values
        repeat (2) @(negedge pclk);
        check_outs_zero("reset");
        prst = 1'b0;
        @(negedge pclk);

        // Zero-wait write from requester 0
        xfer(0, 1'b1, 8'h10, 32'hDEAD_BEEF, 0, 32'h0, 1'b0);
        // Requester 1 read with three wait states
        xfer(1, 1'b0, 8'h20, 32'h0, 3, 32'hA5A5_A5A5, 1'b0);
        // Slave error on read
        xfer(1, 1'b0, 8'hFF, 32'h0, 0, 32'h1234_5678, 1'b1);
        drain();

        // Both requesters held: alternate 0,1,0,1
        wait_n  = 0;
        rd_val  = 32'h0BAD_F00D;
        err_val = 1'b0;
        set_req(0, 1'b1, 8'h04, 32'h1111_2222);
        set_req(1, 1'b0, 8'h08, 32'h0);
        for (int i = 0; i < 4; i++)
            expect_rsp((i % 2 != 0) ? 2'b10 : 2'b01, (i % 2 != 0) ? 32'h0BAD_F00D : 32'h0, 1'b0);
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            wait_ready(n);
            check("rr_grant", 64'(req_ready), (i % 2 != 0) ? 64'd2 : 64'd1);
            check("rr_addr",  64'(apb.paddr), (i % 2 != 0) ? 64'h08 : 64'h04);
            if (i == 3) req_valid = 2'b00;
        end
        drain();

        // Reset during ACCESS drops the transfer and restores last_grant
        wait_n = 1000;
        set_req(1, 1'b0, 8'h30, 32'h0);
        req_valid[1] = 1'b1;
        wait_ready(n);
        req_valid[1] = 1'b0;
        @(negedge pclk);
        check("pre_reset_access", 64'({apb.psel, apb.penable}), 64'(2'b11));
        prst = 1'b1;
        @(negedge pclk);
        prst = 1'b0;
        check_outs_zero("midreset");
        wait_n = 0;
        set_req(0, 1'b1, 8'h40, 32'hCAFE_0001);
        set_req(1, 1'b0, 8'h44, 32'h0);
        expect_rsp(2'b01, 32'h0, 1'b0);
        req_valid = 2'b11;
        wait_ready(n);
        check("post_reset_grant", 64'(req_ready), 64'd1);
        req_valid = 2'b00;
        drain();
        repeat (3) @(negedge pclk);

        // ACCESS with pready held low
        wait_n = 1000;
        rd_val = 32'h7777_7777;
        set_req(0, 1'b0, 8'h50, 32'h0);
`ifdef APB_ARB_TIMEOUT_EN
        expect_rsp(2'b01, 32'h0, 1'b1);
`endif
        req_valid[0] = 1'b1;
        wait_ready(n);
        req_valid[0] = 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
        n = 0;
        do begin
            @(negedge pclk);
            if (rsp_valid == 2'b00 && apb.penable) n++;
        end while (rsp_valid == 2'b00 && n < 100);
        check("timeout_cycles", 64'(n), 64'(TIMEOUT_CYCLES));
        check("timeout_idle",   64'({apb.psel, apb.penable}), 64'd0);
        wait_n = 0;
        repeat (3) @(negedge pclk);
        drain();
`else
        held = 0;
        for (int i = 0; i < 120; i++) begin
            @(negedge pclk);
            if (apb.psel && apb.penable && rsp_valid == 2'b00) held++;
        end
        check("hang_hold", 64'(held), 64'd120);
        prst = 1'b1;
        @(negedge pclk);
        prst   = 1'b0;
        wait_n = 0;
        check_outs_zero("hang_reset");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_master_arbiter.md
# apb_master_arbiter

Two-requester APB master that shares one APB bus between two internal requesters and drives the APB slave through the `apb_interface` signal set. It arbitrates round-robin and sequences the APB SETUP/ACCESS protocol, including wait states. It returns read data and error status to the granted requester. It sits between the test/stimulus agents (or on-chip masters) and `apb_slave`.

## Interface
- `ADDR_W`, default 8: APB address width
- `DATA_W`, default 32: APB data width
- `TIMEOUT_CYCLES`, default 16: ACCESS cycles without `pready` before abort; used only with `APB_ARB_TIMEOUT_EN`
- `pclk` in 1: clock, rising edge
- `prst` in 1: reset, synchronous, active-high
- `req_valid` in 2: per-requester transfer request; requester holds it until it sees `req_ready`
- `req_write` in 2: per-requester direction, 1 = write
- `req_addr` in 2*ADDR_W: requester i occupies slice [i*ADDR_W +: ADDR_W]
- `req_wdata` in 2*DATA_W: requester i occupies slice [i*DATA_W +: DATA_W]
- `req_ready` out 2: one-cycle accept pulse to the granted requester
- `rsp_valid` out 2: one-cycle completion pulse to the granted requester
- `rsp_rdata` out DATA_W: read data, valid with `rsp_valid`
- `rsp_err` out 1: error flag, valid with `rsp_valid`
- `psel`, `penable`, `pwrite` out 1 each: APB control
- `paddr` out ADDR_W: APB address
- `pwdata` out DATA_W: APB write data
- `prdata` in DATA_W, `pready` in 1, `pslverr` in 1: APB slave response

## Operation
- FSM states are IDLE, SETUP and ACCESS (`apb_arb_state_e`).
- IDLE:
  - If any `req_valid` is high, compute the grant and go to SETUP.
  - On that edge, register `paddr`, `pwdata` and `pwrite` from the granted slices and record the grant in `last_grant`.
- Grant rules:
  - Only one requester valid: grant it.
  - Both valid: grant the requester that is not `last_grant`.
  - `last_grant` resets to 1, so requester 0 wins the first tie.
- SETUP:
  - `psel`=1, `penable`=0, `req_ready[g]`=1 (registered, exactly this cycle).
  - Unconditionally go to ACCESS.
- ACCESS:
  - `psel`=1, `penable`=1. Hold `paddr`/`pwdata`/`pwrite` stable.
  - On an edge with `pready`=1, go to IDLE.
  - On that same edge, register `rsp_valid[g]`=1, `rsp_err`=`pslverr`, and `rsp_rdata`=`prdata` for reads or 0 for writes.
- The requester must drop or change `req_valid` after seeing `req_ready`. A still-high `req_valid` in the next IDLE is treated as a new request.
- `paddr`/`pwdata`/`pwrite` hold their last values in IDLE. `psel`/`penable` are 0 in IDLE.
- Reset mid-operation: the in-flight transfer is dropped silently, with no `rsp_valid`.

## Timing
- Reset values:
  - All outputs 0 (`psel`, `penable`, `pwrite`, `paddr`, `pwdata`, `req_ready`, `rsp_valid`, `rsp_rdata`, `rsp_err`).
  - State IDLE, `last_grant`=1.
- Latency from `req_valid` sampled high at edge k:
  - SETUP in cycle k+1.
  - ACCESS in cycle k+2.
  - `rsp_valid` in cycle k+3 when there are zero wait states.
- Each wait state (`pready`=0 in ACCESS) adds one cycle.
- Minimum 3 cycles per transfer: one IDLE cycle always separates transfers.
- `rsp_valid` and `req_ready` are single-cycle pulses and never both high for the same requester.

## Configuration
- `APB_ARB_TIMEOUT_EN` defined:
  - An internal counter clears on entering ACCESS and increments on each ACCESS cycle with `pready`=0.
  - When it reaches `TIMEOUT_CYCLES` without `pready`, go to IDLE and pulse `rsp_valid[g]` with `rsp_err`=1 and `rsp_rdata`=0.
  - A late `pready` is then ignored.
- `APB_ARB_TIMEOUT_EN` undefined: no counter; ACCESS waits indefinitely for `pready`.

## Structure
- `apb_pkg` gains `apb_arb_state_e` and the default width constants `APB_ADDR_W`/`APB_DATA_W`.
- One sub-module, `apb_rr_arbiter`: 2-way round-robin grant logic (inputs `req_valid`, `last_grant`; outputs `grant`, `grant_any`).
- FSM, address/data registers and the timeout counter stay in `apb_master_arbiter`.

## Test plan
- Requester 0 writes 0xDEADBEEF to 0x10 with `pready` tied 1 -> SETUP at k+1, ACCESS at k+2, `paddr`=0x10, `pwdata`=0xDEADBEEF, `pwrite`=1, `rsp_valid`=2'b01 at k+3, `rsp_err`=0.
- Both requesters hold `req_valid` continuously (r0 write 0x04, r1 read 0x08) -> grant order 0,1,0,1; each `rsp_valid` pulse goes to the matching requester.
- Requester 1 reads 0x20 with `pready` low for 3 ACCESS cycles and `prdata`=0xA5A5A5A5 -> ACCESS lasts 4 cycles with APB signals stable; `rsp_rdata`=0xA5A5A5A5 and `rsp_valid`=2'b10.
- Read of 0xFF with `pslverr`=1 and `pready`=1 -> `rsp_err`=1 alongside `rsp_valid`.
- `prst` asserted for 1 cycle during ACCESS -> all outputs 0 the next cycle, no `rsp_valid`; after release, simultaneous requests grant requester 0 first.
- `APB_ARB_TIMEOUT_EN` defined, `TIMEOUT_CYCLES`=16, `pready` held 0 -> IDLE after 16 ACCESS cycles with `rsp_err`=1 and `rsp_rdata`=0; without the macro, `psel`/`penable` remain 1 for 100+ cycles.
